divisor_sequencial: RTL and testbench
=====================================

// Module: divisor_sequencial
// PURPOSE
//   Sequential restoring divider for the 8-bit RPN ALU; Q = A / B, R = A % B.
//   Sits upstream of ULA_comb, beside the sequential multiplier. It takes A/B from the
//   operand stack and a start pulse from the control FSM. Its done pulse loads the
//   division result registers and releases the FSM stall in state 10.
//   Unsigned integer division. Divide-by-zero is flagged, not computed.
// PARAMETERS
//   WIDTH  8  operand, quotient and remainder width in bits
// PORTS
//   clk        in   1      system clock; all state updates on the rising edge
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      one-cycle request pulse; operands sampled with it
//   A          in   WIDTH  dividend (unsigned)
//   B          in   WIDTH  divisor (unsigned)
//   busy       out  1      high while an iteration is in progress (state CALC)
//   done       out  1      one-cycle pulse; Q/R/erro/r_exists valid from this cycle
//   Q          out  WIDTH  quotient
//   R          out  WIDTH  remainder
//   erro       out  1      divide-by-zero flag of the last operation
//   r_exists   out  1      high when the last R != 0 (drives the remainder LED)
// BEHAVIOUR
//   Reset: the rst assertion is asynchronous. The reset values below hold while rst is high.
//     - state = IDLE
//     - busy = done = erro = r_exists = 0
//     - Q = R = 0
//     - internal counter and working registers = 0
//   States: IDLE, CALC, DONE.
//     - IDLE: on an edge with start=1, latch A and B.
//         B != 0: go to CALC, count = 0, working remainder (WIDTH+1 bits) = 0,
//           working dividend = A.
//         B == 0: go to DONE directly. Load Q = 0, R = 0, erro = 1, r_exists = 0.
//     - CALC: performs one restoring step per edge:
//         1. rem = {rem[WIDTH-1:0], dvd[WIDTH-1]}; dvd = dvd << 1.
//         2. If rem >= B_latched: rem = rem - B_latched and dvd[0] = 1.
//       After the WIDTH-th step, go to DONE. On that same edge load:
//         Q = dvd, R = rem[WIDTH-1:0], erro = 0, r_exists = (R != 0).
//     - DONE: done = 1 for exactly one cycle. The next edge goes to IDLE.
//       If start=1 on that edge, the request is accepted as if in IDLE
//       (back-to-back operation).
//   Latency: the start is sampled at edge k.
//     - B != 0: done is high in the cycle after edge k+WIDTH (8 cycles at WIDTH=8).
//     - B == 0: done is high in the cycle after edge k.
//   busy = (state == CALC); done = (state == DONE); both are decoded from registered state.
//   Q, R, erro and r_exists change only on the edge entering DONE (or on reset).
//     They hold their values through IDLE and through the following CALC, until the next DONE.
//   start while in CALC is ignored. No queueing, and no restart of the current operation.
//   A/B changes after the sampling edge have no effect. Only the latched copies are used.
//   Comparison and subtraction are (WIDTH+1)-bit unsigned. The remainder never exceeds B-1.
//     The quotient never overflows. There is no ov output.
//   rst mid-operation (any state): immediate abort to the reset values. No done pulse for the
//     aborted operation, and the prior Q/R are lost.
// TESTING
//   1. A=200, B=7, start at edge 0 -> busy for 8 cycles; done after edge 8;
//      Q=28, R=4, r_exists=1, erro=0.
//   2. A=255, B=1 -> Q=255, R=0, r_exists=0. Also A=3, B=10 -> Q=0, R=3, r_exists=1.
//   3. A=5, B=0 -> done one cycle after start, busy never high; erro=1, Q=0, R=0.
//      Then A=9, B=3 -> erro clears, Q=3, R=0.
//   4. A=100, B=9 with start re-pulsed at cycles 3 and 5 and A/B changed mid-run
//      -> single done at 8 cycles; Q=11, R=1.
//   5. rst pulse at cycle 4 of A=200, B=7 -> all outputs 0 immediately; no done; IDLE.
//      A fresh start afterwards gives the correct result.
//   6. start held high in the DONE cycle of A=50, B=5 (Q=10) with new A=17, B=4
//      -> second done exactly 8 cycles later; Q=4, R=1.

Source files
------------

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider for the RPN ALU: Q = A / B, R = A % B, one quotient bit per clock.
// Divide-by-zero skips the iteration and reports erro in the cycle after start.
//
//   state | meaning
//   IDLE  | waiting for start; results from the last operation held
//   CALC  | one restoring shift/subtract step per edge, WIDTH steps total
//   DONE  | one-cycle done pulse; a start here is accepted as in IDLE
module divisor_sequencial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             erro,
  output logic             r_exists
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] b_lat;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] dvd_nx;

  // One restoring step; the compare is WIDTH+1 bits wide so the shifted-in MSB is never lost.
  always_comb begin
    rem_sh = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    dvd_nx = dvd << 1;
    rem_nx = rem_sh;
    if (rem_sh >= {1'b0, b_lat}) begin
      rem_nx    = rem_sh - {1'b0, b_lat};
      dvd_nx[0] = 1'b1;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      dvd      <= '0;
      b_lat    <= '0;
      Q        <= '0;
      R        <= '0;
      erro     <= 1'b0;
      r_exists <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            b_lat <= B;
            if (B != '0) begin
              state <= CALC;
              count <= '0;
              rem   <= '0;
              dvd   <= A;
            end else begin
              state    <= DONE;
              Q        <= '0;
              R        <= '0;
              erro     <= 1'b1;
              r_exists <= 1'b0;
            end
          end
        end
        CALC: begin
          rem   <= rem_nx;
          dvd   <= dvd_nx;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state    <= DONE;
            Q        <= dvd_nx;
            R        <= rem_nx[WIDTH-1:0];
            erro     <= 1'b0;
            r_exists <= (rem_nx[WIDTH-1:0] != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed bench for divisor_sequencial: latency, results, divide-by-zero, ignored starts,
// mid-operation reset and back-to-back requests.
module tb_divisor_sequencial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       busy, done, erro, r_exists;
  logic [7:0] Q, R;

  int total = 0;
  int bad   = 0;

  divisor_sequencial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .erro(erro), .r_exists(r_exists)
  );

  always #5 clk = ~clk;

  // Called at the first falling edge after the sampling edge; lat = edges from start to done.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic go(input logic [7:0] a, input logic [7:0] b, output int lat, output int bcnt);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, erro, r_exists, Q, R} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b erro=%b rex=%b Q=%0d R=%0d want all 0",
               busy, done, erro, r_exists, Q, R);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    go(8'd200, 8'd7, lat, bcnt);
    total++;
    if (lat !== 8) begin bad++; $display("FAIL basic_latency got %0d want 8", lat); end
    total++;
    if (bcnt !== 8) begin bad++; $display("FAIL basic_busy_cycles got %0d want 8", bcnt); end
    total++;
    if (Q !== 8'd28 || R !== 8'd4 || r_exists !== 1'b1 || erro !== 1'b0) begin
      bad++;
      $display("FAIL basic_result got Q=%0d R=%0d rex=%b erro=%b want 28 4 1 0", Q, R, r_exists, erro);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || Q !== 8'd28) begin
      bad++;
      $display("FAIL basic_done_pulse got done=%b busy=%b Q=%0d want 0 0 28", done, busy, Q);
    end
  endtask

  task automatic test_edges();
    int lat, bcnt;
    go(8'd255, 8'd1, lat, bcnt);
    total++;
    if (lat !== 8 || Q !== 8'd255 || R !== 8'd0 || r_exists !== 1'b0 || erro !== 1'b0) begin
      bad++;
      $display("FAIL div_by_one got lat=%0d Q=%0d R=%0d rex=%b erro=%b want 8 255 0 0 0",
               lat, Q, R, r_exists, erro);
    end
    go(8'd3, 8'd10, lat, bcnt);
    total++;
    if (lat !== 8 || Q !== 8'd0 || R !== 8'd3 || r_exists !== 1'b1) begin
      bad++;
      $display("FAIL small_dividend got lat=%0d Q=%0d R=%0d rex=%b want 8 0 3 1", lat, Q, R, r_exists);
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    go(8'd5, 8'd0, lat, bcnt);
    total++;
    if (lat !== 0 || bcnt !== 0) begin
      bad++;
      $display("FAIL divzero_timing got lat=%0d busy_cycles=%0d want 0 0", lat, bcnt);
    end
    total++;
    if (erro !== 1'b1 || Q !== 8'd0 || R !== 8'd0 || r_exists !== 1'b0) begin
      bad++;
      $display("FAIL divzero_result got erro=%b Q=%0d R=%0d rex=%b want 1 0 0 0", erro, Q, R, r_exists);
    end
    go(8'd9, 8'd3, lat, bcnt);
    total++;
    if (lat !== 8 || erro !== 1'b0 || Q !== 8'd3 || R !== 8'd0 || r_exists !== 1'b0) begin
      bad++;
      $display("FAIL after_divzero got lat=%0d erro=%b Q=%0d R=%0d rex=%b want 8 0 3 0 0",
               lat, erro, Q, R, r_exists);
    end
  endtask

  task automatic test_ignore_start();
    int lat, dones;
    @(negedge clk);
    A = 8'd100; B = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (n == 3 || n == 5) begin
        start = 1'b1; A = 8'd7; B = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (lat !== 8 || Q !== 8'd11 || R !== 8'd1) begin
      bad++;
      $display("FAIL ignore_start got lat=%0d Q=%0d R=%0d want 8 11 1", lat, Q, R);
    end
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL no_queued_op got %0d active cycles want 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, dones;
    @(negedge clk);
    A = 8'd200; B = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, erro, r_exists, Q, R} !== 20'h0) begin
      bad++;
      $display("FAIL reset_mid got busy=%b done=%b erro=%b rex=%b Q=%0d R=%0d want all 0",
               busy, done, erro, r_exists, Q, R);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    total++;
    if (dones !== 0 || Q !== 8'd0) begin
      bad++;
      $display("FAIL reset_abort got active=%0d Q=%0d want 0 0", dones, Q);
    end
    go(8'd200, 8'd7, lat, bcnt);
    total++;
    if (lat !== 8 || Q !== 8'd28 || R !== 8'd4) begin
      bad++;
      $display("FAIL after_reset_op got lat=%0d Q=%0d R=%0d want 8 28 4", lat, Q, R);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    go(8'd50, 8'd5, lat, bcnt);
    total++;
    if (lat !== 8 || Q !== 8'd10 || R !== 8'd0 || r_exists !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first got lat=%0d Q=%0d R=%0d rex=%b want 8 10 0 0", lat, Q, R, r_exists);
    end
    A = 8'd17; B = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || Q !== 8'd10) begin
      bad++;
      $display("FAIL b2b_hold got busy=%b Q=%0d want 1 10", busy, Q);
    end
    wait_done(lat, bcnt);
    total++;
    if (lat !== 8 || Q !== 8'd4 || R !== 8'd1 || r_exists !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got lat=%0d Q=%0d R=%0d rex=%b want 8 4 1 1", lat, Q, R, r_exists);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
